// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM data-memory controller: state encoding, address-split widths
// and the default CPU base address of the SRAM window.
package sram_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ACC_LO = 3'd1;
    localparam logic [STATE_W-1:0] ST_ACC_HI = 3'd2;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = ST_IDLE,
        ACC_LO = ST_ACC_LO,
        ACC_HI = ST_ACC_HI,
        WAIT   = ST_WAIT,
        DONE   = ST_DONE
    } state_e;

    localparam int DEFAULT_MEM_BASE = 1024;

    // A CPU word is two SRAM halfwords; the byte offset inside the word is dropped.
    localparam int HALF_W     = 16;
    localparam int BYTE_OFS_W = 2;
    localparam int HALF_SEL_W = 1;
    localparam int WAIT_CNT_W = 4;

    function automatic logic [WAIT_CNT_W-1:0] clamp_wait(input int n);
        if (n < 1)
            return WAIT_CNT_W'(1);
        else if (n > 15)
            return WAIT_CNT_W'(15);
        else
            return WAIT_CNT_W'(n);
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Settle-time down-counter: loaded with WAIT_CYCLES on entry to WAIT, counts down while in WAIT.
// done_o flags the cycle in which the count reaches zero.
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = clamp_wait(WAIT_CYCLES);
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - WAIT_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Looking at the next count lets the FSM leave WAIT after exactly WAIT_CYCLES cycles.
    assign done_o = (cnt_d == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory: splits each 32-bit load/store into two 16-bit SRAM accesses, freezing the
// pipeline via ready. Optional settle cycles via SRAM_CTRL_WAIT_STATES_EN.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int BIT_NUMBER  = 32,
    parameter int SRAM_ADDR_W = 18,
    parameter int MEM_BASE    = DEFAULT_MEM_BASE,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [BIT_NUMBER-1:0]  address,
    input  logic [BIT_NUMBER-1:0]  write_data,
    output logic [BIT_NUMBER-1:0]  read_data,
    output logic                   ready,
    inout  wire  [HALF_W-1:0]      SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N
);

    localparam int WORD_W = SRAM_ADDR_W - HALF_SEL_W;

    state_e                  state_q;
    logic                    op_we_q;
    logic [WORD_W-1:0]       word_q;
    logic [HALF_W-1:0]       wdata_hi_q;
    logic [BIT_NUMBER-1:0]   read_data_q;
    logic [SRAM_ADDR_W-1:0]  sram_addr_q;
    logic                    we_n_q;
    logic                    dq_oe_q;
    logic [HALF_W-1:0]       dq_out_q;

    logic [BIT_NUMBER-1:0]   eff;
    logic [WORD_W-1:0]       word_d;
    logic                    req;
    logic                    wait_done;
    logic                    unused_eff;

    assign req    = rd_en | wr_en;
    assign eff    = address - BIT_NUMBER'(MEM_BASE);
    assign word_d = eff[WORD_W+BYTE_OFS_W-1:BYTE_OFS_W];
    assign unused_eff = ^{eff[BIT_NUMBER-1:WORD_W+BYTE_OFS_W], eff[BYTE_OFS_W-1:0]};

`ifdef SRAM_CTRL_WAIT_STATES_EN
    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == ACC_HI),
        .dec_i  (state_q == WAIT),
        .done_o (wait_done)
    );
`else
    // WAIT is unreachable in this build, so WAIT_CYCLES has no effect.
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^clamp_wait(WAIT_CYCLES);
    assign wait_done       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_we_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        // Simultaneous rd_en/wr_en resolves to a store.
                        state_q     <= ACC_LO;
                        op_we_q     <= wr_en;
                        word_q      <= word_d;
                        wdata_hi_q  <= write_data[BIT_NUMBER-1:HALF_W];
                        sram_addr_q <= {word_d, 1'b0};
                        we_n_q      <= ~wr_en;
                        dq_oe_q     <= wr_en;
                        dq_out_q    <= write_data[HALF_W-1:0];
                    end
                end
                ACC_LO: begin
                    if (!op_we_q)
                        read_data_q[HALF_W-1:0] <= SRAM_DQ;
                    state_q     <= ACC_HI;
                    sram_addr_q <= {word_q, 1'b1};
                    we_n_q      <= ~op_we_q;
                    dq_oe_q     <= op_we_q;
                    dq_out_q    <= wdata_hi_q;
                end
                ACC_HI: begin
                    if (!op_we_q)
                        read_data_q[BIT_NUMBER-1:HALF_W] <= SRAM_DQ;
                    we_n_q  <= 1'b1;
                    dq_oe_q <= 1'b0;
`ifdef SRAM_CTRL_WAIT_STATES_EN
                    state_q <= WAIT;
`else
                    state_q <= DONE;
`endif
                end
                WAIT: begin
                    if (wait_done)
                        state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ~req | (state_q == DONE);
    assign read_data = read_data_q;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {HALF_W{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed test-plan steps followed by random loads/stores, checked
// against a word-level memory model.
module tb_sram_controller;

    localparam int WAIT_CYCLES = 2;
    localparam int MEM_BASE    = 1024;
`ifdef SRAM_CTRL_WAIT_STATES_EN
    localparam int EXP_LAT = 3 + WAIT_CYCLES;
`else
    localparam int EXP_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    sram_controller #(
        .BIT_NUMBER  (32),
        .SRAM_ADDR_W (18),
        .MEM_BASE    (MEM_BASE),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // Small external SRAM: drives the bus whenever it is not being written.
    logic [15:0] sram [0:63];
    bit          mem_init;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) + 16'h1357);
    endfunction

    always @(negedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++)
                sram[i] <= init_val(i);
        end else if (!SRAM_WE_N) begin
            sram[SRAM_ADDR[5:0]] <= SRAM_DQ;
        end
    end

    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR[5:0]] : 16'hzzzz;

    // Reference model: memory as 32-bit words, plus the expected read_data register.
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] ref_word(input int w);
        if (ref_mem.exists(w))
            return ref_mem[w];
        return {init_val(2 * w + 1), init_val(2 * w)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input bit r, input bit w,
                         input logic [31:0] a, input logic [31:0] d);
        int          lat;
        int          wecnt;
        int          widx;
        bit          seen;
        logic [31:0] rd_done;
        @(posedge clk);
        #1;
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = d;
        lat = 0;
        wecnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (SRAM_WE_N == 1'b0)
                wecnt++;
            if (ready)
                seen = 1'b1;
            else
                lat++;
        end
        rd_done = read_data;
        chk({tag, "/completed"}, 32'(seen), 32'd1);
        chk({tag, "/ready_low_cycles"}, 32'(lat), 32'(EXP_LAT));
        widx = int'((a - 32'(MEM_BASE)) >> 2);
        if (w) begin
            ref_mem[widx] = d;
            chk({tag, "/we_low_cycles"}, 32'(wecnt), 32'd2);
            chk({tag, "/sram_lo"}, {16'h0, sram[2 * widx]}, {16'h0, d[15:0]});
            chk({tag, "/sram_hi"}, {16'h0, sram[2 * widx + 1]}, {16'h0, d[31:16]});
        end else begin
            exp_rd = ref_word(widx);
            chk({tag, "/we_low_cycles"}, 32'(wecnt), 32'd0);
        end
        chk({tag, "/read_data"}, rd_done, exp_rd);
    endtask

    task automatic go_idle(input int n);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;
        mem_init = 1'b1;
        exp_rd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        chk("reset/read_data", read_data, 32'd0);
        chk("reset/we_n", 32'(SRAM_WE_N), 32'd1);
        chk("reset/sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("reset/ready", 32'(ready), 32'd1);
        chk("reset/dq_released", {16'h0, SRAM_DQ}, {16'h0, init_val(0)});

        do_op("store_deadbeef", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        do_op("load_1024", 1'b1, 1'b0, 32'd1024, 32'h0);
        go_idle(2);

        do_op("store_1036", 1'b0, 1'b1, 32'd1036, 32'h12345678);
        go_idle(1);
        do_op("load_1037", 1'b1, 1'b0, 32'd1037, 32'h0);

        go_idle(1);
        do_op("b2b_load", 1'b1, 1'b0, 32'd1024, 32'h0);
        do_op("b2b_store", 1'b0, 1'b1, 32'd1028, 32'h0BADF00D);

        do_op("rd_and_wr", 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5);
        do_op("load_back", 1'b1, 1'b0, 32'd1040, 32'h0);

        // Abort a load while it is in ACC_HI.
        do_op("preload", 1'b1, 1'b0, 32'd1024, 32'h0);
        @(posedge clk);
        #1;
        rd_en = 1'b1;
        wr_en = 1'b0;
        address = 32'd1028;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("midrst/read_data", read_data, 32'd0);
        chk("midrst/we_n", 32'(SRAM_WE_N), 32'd1);
        chk("midrst/sram_addr", 32'(SRAM_ADDR), 32'd0);
        chk("midrst/ready", 32'(ready), 32'd1);
        chk("midrst/dq_released", {16'h0, SRAM_DQ}, {16'h0, sram[0]});
        rst = 1'b0;
        exp_rd = 32'd0;
        do_op("after_rst_load", 1'b1, 1'b0, 32'd1028, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            do_op("rand", kind != 1, kind != 0,
                  32'(MEM_BASE) + 32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0)
                go_idle(int'($urandom_range(0, 2)));
        end
        go_idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
